// File: rtl/evm_ballot_unit.sv
// evm_ballot_unit: conditions three candidate buttons and gates them into one vote per issued ballot.
// Optional BALLOT_TIMEOUT_EN expires an unused ballot after TIMEOUT_CYCLES in READY.
module evm_ballot_unit #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 32,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_a,
  input  logic btn_b,
  input  logic btn_c,
  input  logic ballot_issue,
  input  logic poll_open,
  output logic vote_a,
  output logic vote_b,
  output logic vote_c,
  output logic ready_led,
  output logic busy,
  output logic reject,
  output logic timeout
);
  typedef enum logic [1:0] {IDLE, READY, CAST, LOCK} state_t;
  logic [2:0] btn, sync1_q, sync2_q, deb_q, deb_d, deb_prev_q, press_q, press_d;
  logic [2:0][15:0] cnt_q, cnt_d;
  state_t state_q;
  logic bi_q, ready_q, busy_q, reject_q, bi_rise, single;
  logic [2:0] vote_q;
  logic [15:0] lock_q;
`ifdef BALLOT_TIMEOUT_EN
  logic [23:0] tmo_q;
  logic timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif
  assign btn = {btn_c, btn_b, btn_a};
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      deb_d[i] = (sync2_q[i] != deb_q[i] && cnt_q[i] == 16'(DEBOUNCE_CYCLES - 1)) ? ~deb_q[i] : deb_q[i];
      cnt_d[i] = (sync2_q[i] != deb_q[i] && cnt_q[i] != 16'(DEBOUNCE_CYCLES - 1)) ? cnt_q[i] + 16'd1 : 16'd0;
    end
    press_d = deb_q & ~deb_prev_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      press_q    <= press_d;
      cnt_q      <= cnt_d;
    end
  end
  assign bi_rise = ballot_issue & ~bi_q;
  // a press is only clean if no other button is already held down
  assign single = $onehot(press_q) && ((deb_q & ~press_q) == 3'b000);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bi_q     <= 1'b0;
      lock_q   <= '0;
      vote_q   <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      reject_q <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
      tmo_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      bi_q     <= ballot_issue;
      vote_q   <= '0;
      reject_q <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      if (!poll_open && state_q != CAST) begin
        state_q <= IDLE;
        ready_q <= 1'b0;
        busy_q  <= 1'b0;
        lock_q  <= '0;
`ifdef BALLOT_TIMEOUT_EN
        tmo_q   <= '0;
`endif
      end else begin
        case (state_q)
          IDLE: if (bi_rise) begin
            state_q <= READY;
            ready_q <= 1'b1;
`ifdef BALLOT_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
          READY: if (single) begin
            state_q <= CAST;
            ready_q <= 1'b0;
            vote_q  <= press_q;
          end else begin
            reject_q <= |press_q;
`ifdef BALLOT_TIMEOUT_EN
            if (tmo_q == 24'(TIMEOUT_CYCLES - 1)) begin
              state_q   <= IDLE;
              ready_q   <= 1'b0;
              timeout_q <= 1'b1;
            end else tmo_q <= tmo_q + 24'd1;
`endif
          end
          CAST: begin
            state_q <= poll_open ? LOCK : IDLE;
            busy_q  <= poll_open;
            lock_q  <= '0;
          end
          default: if (lock_q == 16'(LOCKOUT_CYCLES - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else lock_q <= lock_q + 16'd1;
        endcase
      end
    end
  end
  assign {vote_c, vote_b, vote_a} = vote_q;
  assign ready_led = ready_q;
  assign busy      = busy_q;
  assign reject    = reject_q;
endmodule

// File: tb/tb_evm_ballot_unit.sv
// tb_evm_ballot_unit: directed test-plan scenarios plus random stimulus against a window-rule ballot model.
module tb_evm_ballot_unit;
  localparam int DEB = 4, LCK = 8, TMO = 20;
`ifdef BALLOT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, btn_a = 1'b0, btn_b = 1'b0, btn_c = 1'b0;
  logic ballot_issue = 1'b0, poll_open = 1'b1;
  logic vote_a, vote_b, vote_c, ready_led, busy, reject, timeout;

  evm_ballot_unit #(.DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(LCK), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c),
    .ballot_issue(ballot_issue), .poll_open(poll_open),
    .vote_a(vote_a), .vote_b(vote_b), .vote_c(vote_c),
    .ready_led(ready_led), .busy(busy), .reject(reject), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_READY, M_CAST, M_LOCK} mode_t;
  int n_checks = 0, n_fail = 0, cyc = 0, rise = 0;
  int n_va, n_vb, n_vc, n_rej, n_tmo, n_busy, vb_cyc;
  mode_t mode = M_IDLE;
  int lock_left = 0, ready_age = 0;
  bit bi_prev;
  bit [2:0] m_deb, m_deb_old, m_press, e_vote;
  bit e_reject, e_timeout;
  bit [DEB+1:0] hist [3];

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  // A level flips once DEB consecutive synchronised samples (raw delayed two edges) disagree with it.
  task automatic model_step();
    bit [2:0] raw, flip;
    int np;
    raw = {btn_c, btn_b, btn_a};
    np = $countones(m_press);
    e_vote = '0;
    e_reject = 1'b0;
    e_timeout = 1'b0;
    flip = '0;
    if (rst) begin
      mode = M_IDLE;
      lock_left = 0;
      ready_age = 0;
      bi_prev = 1'b0;
      m_deb = '0;
      m_deb_old = '0;
      m_press = '0;
      for (int i = 0; i < 3; i++) hist[i] = '0;
      return;
    end
    if (!poll_open && mode != M_CAST) mode = M_IDLE;
    else if (mode == M_IDLE) begin
      if (ballot_issue && !bi_prev) begin
        mode = M_READY;
        ready_age = 0;
      end
    end else if (mode == M_READY) begin
      if (np == 1 && (m_deb & ~m_press) == 3'b000) begin
        mode = M_CAST;
        e_vote = m_press;
      end else begin
        e_reject = np > 0;
        ready_age++;
        if (TMO_EN && ready_age == TMO) begin
          mode = M_IDLE;
          e_timeout = 1'b1;
        end
      end
    end else if (mode == M_CAST) begin
      mode = poll_open ? M_LOCK : M_IDLE;
      lock_left = LCK;
    end else begin
      lock_left--;
      if (lock_left == 0) mode = M_IDLE;
    end
    bi_prev = ballot_issue;
    for (int i = 0; i < 3; i++) begin
      hist[i] = {hist[i][DEB:0], raw[i]};
      flip[i] = hist[i][DEB+1:2] == {DEB{~m_deb[i]}};
    end
    m_press = m_deb & ~m_deb_old;
    m_deb_old = m_deb;
    m_deb = m_deb ^ flip;
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      check("vote_a", vote_a, e_vote[0]);
      check("vote_b", vote_b, e_vote[1]);
      check("vote_c", vote_c, e_vote[2]);
      check("ready_led", ready_led, mode == M_READY);
      check("busy", busy, mode == M_LOCK);
      check("reject", reject, e_reject);
      check("timeout", timeout, e_timeout);
      n_va += int'(vote_a);
      n_vb += int'(vote_b);
      n_vc += int'(vote_c);
      n_rej += int'(reject);
      n_tmo += int'(timeout);
      n_busy += int'(busy);
      if (vote_b) vb_cyc = cyc;
    end
  endtask

  task automatic clear_counts();
    n_va = 0; n_vb = 0; n_vc = 0; n_rej = 0; n_tmo = 0; n_busy = 0; vb_cyc = -1;
  endtask

  task automatic pulse_ballot();
    ballot_issue = 1'b1;
    tick(1);
    ballot_issue = 1'b0;
  endtask

  initial begin
    clear_counts();
    rst = 1'b1;
    tick(3);
    check("rst_outputs", {vote_a, vote_b, vote_c, ready_led, busy, reject, timeout}, 7'd0);
    rst = 1'b0;
    tick(2);
    // single clean vote for B
    clear_counts();
    pulse_ballot();
    check("s1_ready", ready_led, 1);
    btn_b = 1'b1;
    rise = cyc;
    tick(10);
    btn_b = 1'b0;
    tick(10);
    check("s1_vote_b_count", n_vb, 1);
    check("s1_vote_b_latency", vb_cyc - rise, 8);
    check("s1_busy_len", n_busy, 8);
    check("s1_other_votes", n_va + n_vc, 0);
    check("s1_ready_end", ready_led, 0);
    // glitches and presses with no ballot
    clear_counts();
    repeat (4) begin
      btn_a = 1'b1; tick(3);
      btn_a = 1'b0; tick(3);
    end
    btn_a = 1'b1; tick(20);
    btn_a = 1'b0; tick(10);
    check("s2_votes", n_va + n_vb + n_vc, 0);
    check("s2_rejects", n_rej, 0);
    // simultaneous A+C rejected, then a clean C
    clear_counts();
    pulse_ballot();
    btn_a = 1'b1; btn_c = 1'b1;
    tick(7);
    btn_a = 1'b0; btn_c = 1'b0;
    tick(14);
    check("s3_reject_count", n_rej, 1);
    check("s3_no_vote_yet", n_va + n_vb + n_vc, 0);
    pulse_ballot();
    btn_c = 1'b1;
    tick(12);
    btn_c = 1'b0;
    tick(16);
    check("s3_vote_c_count", n_vc, 1);
    check("s3_vote_a_count", n_va, 0);
    // held button, ballot during lockout, ballot while still held
    clear_counts();
    pulse_ballot();
    btn_a = 1'b1;
    tick(12);
    pulse_ballot();
    tick(35);
    check("s4_lock_ballot_ignored", ready_led, 0);
    pulse_ballot();
    check("s4_ready_while_held", ready_led, 1);
    btn_a = 1'b0;
    tick(6);
    check("s4_no_vote_while_held", n_va, 1);
    btn_a = 1'b1;
    tick(12);
    btn_a = 1'b0;
    tick(16);
    check("s4_vote_a_count", n_va, 2);
    check("s4_busy_len", n_busy, 16);
    // poll closed while READY
    clear_counts();
    pulse_ballot();
    poll_open = 1'b0;
    tick(1);
    check("s5_ready_dropped", ready_led, 0);
    poll_open = 1'b1;
    btn_b = 1'b1;
    tick(12);
    btn_b = 1'b0;
    tick(8);
    check("s5_votes", n_va + n_vb + n_vc, 0);
    // unused ballot
    clear_counts();
    pulse_ballot();
    tick(100);
    check("s6_timeouts", n_tmo, TMO_EN ? 1 : 0);
    check("s6_ready", ready_led, TMO_EN ? 0 : 1);
    poll_open = 1'b0;
    tick(2);
    poll_open = 1'b1;
    tick(2);
    // random traffic
    repeat (4000) begin
      if ($urandom_range(0, 15) == 0) btn_a = ~btn_a;
      if ($urandom_range(0, 15) == 0) btn_b = ~btn_b;
      if ($urandom_range(0, 15) == 0) btn_c = ~btn_c;
      if ($urandom_range(0, 9) == 0) ballot_issue = ~ballot_issue;
      if (poll_open) poll_open = $urandom_range(0, 99) != 0;
      else poll_open = $urandom_range(0, 3) == 0;
      rst = $urandom_range(0, 799) == 0;
      tick(1);
    end
    rst = 1'b0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
